// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and
// operand forwarding selects.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MEMWAIT = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // The younger producer (EX) always wins over the older one (MEM).
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
    if (hit_ex)  return FWD_EX;
    if (hit_mem) return FWD_MEM;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle; the pipeline is the master,
// the controller is the slave.
interface pipe_hazard_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic [RA_W-1:0]  D_rs1;
  logic [RA_W-1:0]  D_rs2;
  logic             D_use_rs1;
  logic             D_use_rs2;
  logic [RA_W-1:0]  D_rd;
  logic             D_we;
  logic             D_ld;
  logic             EX_taken;
  logic             M_req;
  logic             M_ready;
  logic             stall_F;
  logic             stall_D;
  logic             flush_FD;
  logic             freeze;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state;

  modport master (
    output D_rs1, D_rs2, D_use_rs1, D_use_rs2, D_rd, D_we, D_ld,
           EX_taken, M_req, M_ready,
    input  stall_F, stall_D, flush_FD, freeze, fwd_a, fwd_b, stall_cnt, state
  );

  modport slave (
    input  D_rs1, D_rs2, D_use_rs1, D_use_rs2, D_rd, D_we, D_ld,
           EX_taken, M_req, M_ready,
    output stall_F, stall_D, flush_FD, freeze, fwd_a, fwd_b, stall_cnt, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hz_slot.sv
// One scoreboard slot: shadow copy of {rd, we, ld} for a pipeline stage,
// with hold (stage frozen) and clear (bubble inserted).
module hz_slot #(
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            clear,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_we,
  input  logic            in_ld,
  output logic [RA_W-1:0] rd,
  output logic            we,
  output logic            ld
);

  logic [RA_W-1:0] rd_q, rd_d;
  logic            we_q, we_d;
  logic            ld_q, ld_d;

  always_comb begin
    rd_d = rd_q;
    we_d = we_q;
    ld_d = ld_q;
    if (!hold) begin
      rd_d = clear ? '0   : in_rd;
      we_d = clear ? 1'b0 : in_we;
      ld_d = clear ? 1'b0 : in_ld;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
      we_q <= 1'b0;
      ld_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      we_q <= we_d;
      ld_q <= ld_d;
    end
  end

  assign rd = rd_q;
  assign we = we_q;
  assign ld = ld_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: forwarding selects, load-use
// stall, branch flush and memory-wait freeze, plus a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst_n,
  pipe_hazard_if.slave hz
);

  logic [RA_W-1:0]  ex_rd, mem_rd;
  logic             ex_we, ex_ld, mem_we, mem_ld;
  logic             ex_prod, mem_prod;
  logic             ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic             load_use, mem_busy;
  logic             stall_f, stall_d, flush_fd, freeze;
  logic [1:0]       fwd_a, fwd_b;
  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  hz_slot #(.RA_W(RA_W)) u_ex_slot (
    .clk(clk), .rst_n(rst_n), .hold(freeze), .clear(stall_d),
    .in_rd(hz.D_rd), .in_we(hz.D_we), .in_ld(hz.D_ld),
    .rd(ex_rd), .we(ex_we), .ld(ex_ld)
  );

  hz_slot #(.RA_W(RA_W)) u_mem_slot (
    .clk(clk), .rst_n(rst_n), .hold(freeze), .clear(1'b0),
    .in_rd(ex_rd), .in_we(ex_we), .in_ld(ex_ld),
    .rd(mem_rd), .we(mem_we), .ld(mem_ld)
  );

  // A slot writing x0 is never a producer, since x0 reads as zero.
  always_comb begin
    ex_prod   = ex_we  && (ex_rd  != '0);
    mem_prod  = mem_we && (mem_rd != '0);
    ex_hit_a  = hz.D_use_rs1 && ex_prod  && (hz.D_rs1 == ex_rd);
    ex_hit_b  = hz.D_use_rs2 && ex_prod  && (hz.D_rs2 == ex_rd);
    mem_hit_a = hz.D_use_rs1 && mem_prod && (hz.D_rs1 == mem_rd);
    mem_hit_b = hz.D_use_rs2 && mem_prod && (hz.D_rs2 == mem_rd);
    fwd_a     = fwd_sel(ex_hit_a, mem_hit_a);
    fwd_b     = fwd_sel(ex_hit_b, mem_hit_b);
    load_use  = (ex_hit_a || ex_hit_b) && ex_ld;
    mem_busy  = hz.M_req && !hz.M_ready;
  end

  // Freeze beats everything; a pending load-use is simply seen again once
  // memory completes because the scoreboard was held.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    flush_fd = 1'b0;
    freeze   = mem_busy;
    if (!mem_busy) begin
      if (hz.EX_taken) begin
        flush_fd = 1'b1;
        stall_d  = 1'b1;
      end else if (load_use && state_q != ST_LDSTALL) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_busy)                         state_d = ST_MEMWAIT;
        else if (load_use && !hz.EX_taken)    state_d = ST_LDSTALL;
      end
      ST_LDSTALL: state_d = mem_busy ? ST_MEMWAIT : ST_RUN;
      ST_MEMWAIT: if (hz.M_ready) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall_d || freeze) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs read as zero for the whole time reset is held.
  always_comb begin
    hz.stall_F   = rst_n && stall_f;
    hz.stall_D   = rst_n && stall_d;
    hz.flush_FD  = rst_n && flush_fd;
    hz.freeze    = rst_n && freeze;
    hz.fwd_a     = rst_n ? fwd_a : FWD_RF;
    hz.fwd_b     = rst_n ? fwd_b : FWD_RF;
    hz.stall_cnt = rst_n ? stall_cnt_q : '0;
    hz.state     = rst_n ? 2'(state_q) : 2'(ST_RUN);
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard-driven bench for pipe_hazard_ctrl: each scenario queues stimulus
// with hand-derived expected outputs and checks them one cycle at a time.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_if #(.RA_W(5), .CNT_W(16)) hz ();
  pipe_hazard_if #(.RA_W(5), .CNT_W(3))  hz2 ();

  pipe_hazard_ctrl #(.RA_W(5), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
  pipe_hazard_ctrl #(.RA_W(5), .CNT_W(3))  dut_sat (.clk(clk), .rst_n(rst_n), .hz(hz2));

  // stim  = {rst_n, rs1, rs2, use1, use2, rd, we, ld, taken, m_req, m_ready}
  // expect = {state, stall_F, stall_D, flush_FD, freeze, fwd_a, fwd_b, stall_cnt}
  logic [22:0] stim_q[$];
  logic [25:0] exp_q[$];
  logic [5:0]  sat_q[$];

  function automatic logic [22:0] st(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic u1, input logic u2, input logic [4:0] rd,
                                     input logic we, input logic ld, input logic tk,
                                     input logic mq, input logic mr);
    return {r, rs1, rs2, u1, u2, rd, we, ld, tk, mq, mr};
  endfunction

  function automatic logic [25:0] ex(input logic [1:0] s, input logic sf, input logic sd,
                                     input logic fl, input logic fz, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic [15:0] c);
    return {s, sf, sd, fl, fz, fa, fb, c};
  endfunction

  function automatic logic [25:0] obs();
    return {hz.state, hz.stall_F, hz.stall_D, hz.flush_FD, hz.freeze, hz.fwd_a, hz.fwd_b, hz.stall_cnt};
  endfunction

  task automatic add(input logic [22:0] s, input logic [25:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic [22:0] s);
    {rst_n, hz.D_rs1, hz.D_rs2, hz.D_use_rs1, hz.D_use_rs2, hz.D_rd, hz.D_we, hz.D_ld,
     hz.EX_taken, hz.M_req, hz.M_ready} = s;
  endtask

  localparam logic [22:0] IDLE = 23'h400000;

  task automatic test_reset();
    logic [25:0] got, want;
    int n = 0;
    add(23'h000000, ex(0,0,0,0,0,0,0,0));
    add(23'h000000, ex(0,0,0,0,0,0,0,0));
    add(IDLE,       ex(0,0,0,0,0,0,0,0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL reset step %0d: got %h want %h", n, got, want);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    logic [25:0] got, want;
    int n = 0;
    add(st(1, 0,0, 0,0, 5,1,1, 0,0,0), ex(0,0,0,0,0,2'b00,2'b00,0));
    add(st(1, 5,0, 1,0, 0,0,0, 0,0,0), ex(0,1,1,0,0,2'b01,2'b00,0));
    add(st(1, 5,0, 1,0, 0,0,0, 0,0,0), ex(1,0,0,0,0,2'b10,2'b00,1));
    add(IDLE,                          ex(0,0,0,0,0,2'b00,2'b00,1));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL load_use step %0d: got %h want %h", n, got, want);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_fwd();
    logic [25:0] got, want;
    int n = 0;
    add(st(1, 0,0, 0,0, 3,1,0, 0,0,0), ex(0,0,0,0,0,2'b00,2'b00,1));
    add(st(1, 0,3, 0,1, 0,0,0, 0,0,0), ex(0,0,0,0,0,2'b00,2'b01,1));
    add(st(1, 3,3, 0,1, 0,0,0, 0,0,0), ex(0,0,0,0,0,2'b00,2'b10,1));
    add(st(1, 0,0, 0,0, 7,1,0, 0,0,0), ex(0,0,0,0,0,2'b00,2'b00,1));
    add(st(1, 0,0, 0,0, 7,1,0, 0,0,0), ex(0,0,0,0,0,2'b00,2'b00,1));
    add(st(1, 7,0, 1,0, 0,0,0, 0,0,0), ex(0,0,0,0,0,2'b01,2'b00,1));
    add(st(1, 7,0, 1,0, 0,0,0, 0,0,0), ex(0,0,0,0,0,2'b10,2'b00,1));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL alu_fwd step %0d: got %h want %h", n, got, want);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rd_zero();
    logic [25:0] got, want;
    int n = 0;
    add(st(1, 0,0, 0,0, 0,1,1, 0,0,0), ex(0,0,0,0,0,2'b00,2'b00,1));
    add(st(1, 0,0, 1,1, 0,0,0, 0,0,0), ex(0,0,0,0,0,2'b00,2'b00,1));
    add(st(1, 0,0, 1,1, 0,0,0, 0,0,0), ex(0,0,0,0,0,2'b00,2'b00,1));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL rd_zero step %0d: got %h want %h", n, got, want);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [25:0] got, want;
    int n = 0;
    add(st(1, 0,0, 0,0, 9,1,1, 0,0,0), ex(0,0,0,0,0,2'b00,2'b00,1));
    add(st(1, 9,0, 1,0, 0,0,0, 1,0,0), ex(0,0,1,1,0,2'b01,2'b00,1));
    add(IDLE,                          ex(0,0,0,0,0,2'b00,2'b00,2));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL branch step %0d: got %h want %h", n, got, want);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_memwait();
    logic [25:0] got, want;
    int n = 0;
    add(23'h000000,                    ex(0,0,0,0,0,2'b00,2'b00,0));
    add(st(1, 0,0, 0,0, 4,1,0, 0,0,0), ex(0,0,0,0,0,2'b00,2'b00,0));
    add(st(1, 0,4, 0,1, 6,1,0, 0,1,0), ex(0,0,0,0,1,2'b00,2'b01,0));
    add(st(1, 0,4, 0,1, 6,1,0, 0,1,0), ex(2,0,0,0,1,2'b00,2'b01,1));
    add(st(1, 0,4, 0,1, 6,1,0, 0,1,0), ex(2,0,0,0,1,2'b00,2'b01,2));
    add(st(1, 0,4, 0,1, 6,1,0, 0,1,0), ex(2,0,0,0,1,2'b00,2'b01,3));
    add(st(1, 0,4, 0,1, 6,1,0, 0,1,1), ex(2,0,0,0,0,2'b00,2'b01,4));
    add(st(1, 6,4, 1,1, 0,0,0, 0,0,0), ex(0,0,0,0,0,2'b01,2'b10,4));
    add(IDLE,                          ex(0,0,0,0,0,2'b00,2'b00,4));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL memwait step %0d: got %h want %h", n, got, want);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_freeze_vs_load_use();
    logic [25:0] got, want;
    int n = 0;
    add(st(1, 0,0, 0,0, 8,1,1, 0,0,0), ex(0,0,0,0,0,2'b00,2'b00,4));
    add(st(1, 8,0, 1,0, 0,0,0, 0,1,0), ex(0,0,0,0,1,2'b01,2'b00,4));
    add(st(1, 8,0, 1,0, 0,0,0, 0,1,1), ex(2,1,1,0,0,2'b01,2'b00,5));
    add(st(1, 8,0, 1,0, 0,0,0, 0,0,0), ex(0,0,0,0,0,2'b10,2'b00,6));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL freeze_vs_load_use step %0d: got %h want %h", n, got, want);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_memwait();
    logic [25:0] got, want;
    int n = 0;
    add(st(1, 0,0, 0,0, 0,0,0, 0,1,0), ex(0,0,0,0,1,2'b00,2'b00,6));
    add(st(1, 0,0, 0,0, 0,0,0, 0,1,0), ex(2,0,0,0,1,2'b00,2'b00,7));
    add(st(0, 0,0, 0,0, 0,0,0, 0,1,0), ex(0,0,0,0,0,2'b00,2'b00,0));
    add(IDLE,                          ex(0,0,0,0,0,2'b00,2'b00,0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL reset_in_memwait step %0d: got %h want %h", n, got, want);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  // A 3-bit counter instance shows saturation without a long run.
  task automatic test_saturate();
    logic [5:0] got, want;
    for (int i = 0; i <= 10; i++) begin
      hz2.M_req   = 1'b1;
      hz2.M_ready = (i == 10);
      if (i == 10)     sat_q.push_back({2'd2, 1'b0, 3'd7});
      else if (i == 0) sat_q.push_back({2'd0, 1'b1, 3'd0});
      else             sat_q.push_back({2'd2, 1'b1, (i > 7) ? 3'd7 : 3'(i)});
      @(negedge clk);
      got = {hz2.state, hz2.freeze, hz2.stall_cnt};
      want = sat_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL saturate step %0d: got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
    hz2.M_req   = 1'b0;
    hz2.M_ready = 1'b0;
  endtask

  initial begin
    apply(23'h000000);
    {hz2.D_rs1, hz2.D_rs2, hz2.D_use_rs1, hz2.D_use_rs2, hz2.D_rd, hz2.D_we, hz2.D_ld,
     hz2.EX_taken, hz2.M_req, hz2.M_ready} = '0;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_rd_zero();
    test_branch();
    test_memwait();
    test_freeze_vs_load_use();
    test_reset_in_memwait();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
